// File: rtl/dummy_stream_fifo_pkg.sv
// rtl/dummy_stream_fifo_pkg.sv - shared defaults and derived-width helper for the stream FIFO
`timescale 1ns/1ps
package dummy_stream_fifo_pkg;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_DEPTH  = 4;

    // Level must represent 0..DEPTH inclusive, hence one bit above the pointer width.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dummy_stream_fifo_if.sv
// rtl/dummy_stream_fifo_if.sv - producer/consumer handshake bundle for the stream FIFO
`timescale 1ns/1ps
interface dummy_stream_fifo_if
    import dummy_stream_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [DATA_W-1:0] data_in_i;
    logic              valid_in_i;
    logic              ready_out_o;
    logic [DATA_W-1:0] data_out_o;
    logic              valid_out_o;
    logic              ready_in_i;
    logic              flush_i;
    logic [LVL_W-1:0]  level_o;
    logic              overflow_o;

    modport master (
        output data_in_i, valid_in_i, ready_in_i, flush_i,
        input  ready_out_o, data_out_o, valid_out_o, level_o, overflow_o
    );

    modport slave (
        input  data_in_i, valid_in_i, ready_in_i, flush_i,
        output ready_out_o, data_out_o, valid_out_o, level_o, overflow_o
    );

endinterface

// File: rtl/dummy_stream_fifo_mem.sv
// rtl/dummy_stream_fifo_mem.sv - DEPTH x DATA_W storage, one write port, one async read port
`timescale 1ns/1ps
module dummy_stream_fifo_mem
    import dummy_stream_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o
);
    // Storage is deliberately unreset; validity is tracked by the level in the top.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/dummy_stream_fifo.sv
// rtl/dummy_stream_fifo.sv - first-word-fall-through stream FIFO with flush and sticky overflow
`timescale 1ns/1ps
module dummy_stream_fifo
    import dummy_stream_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    dummy_stream_fifo_if.slave   bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ready_q, ready_d;
    logic              overflow_q, overflow_d;
    logic              valid_out;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] rd_data;

    assign valid_out = (level_q != '0);
    assign push      = bus.valid_in_i & ready_q;
    assign pop       = valid_out & bus.ready_in_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | (bus.valid_in_i & ~ready_q);
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        end
        // Ready is registered from the next level so it never sees ready_in_i combinationally.
        ready_d = (level_d < LVL_W'(DEPTH));
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
        end
    end

    dummy_stream_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (push & ~bus.flush_i),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (bus.data_in_i),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    // Empty FIFO shows zeros rather than whatever stale word sits at the read pointer.
    assign bus.data_out_o  = valid_out ? rd_data : '0;
    assign bus.valid_out_o = valid_out;
    assign bus.ready_out_o = ready_q;
    assign bus.level_o     = level_q;
    assign bus.overflow_o  = overflow_q;

endmodule

// File: tb/tb_dummy_stream_fifo.sv
// tb/tb_dummy_stream_fifo.sv - randomized scoreboard bench for dummy_stream_fifo
`timescale 1ns/1ps
module tb_dummy_stream_fifo;

    localparam int DATA_W = 128;
    localparam int DEPTH  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    dummy_stream_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    dummy_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    always #1 clk = ~clk;

    logic [DATA_W-1:0] sb [$];
    int  exp_lvl;
    bit  exp_rdy;
    bit  exp_ovf;
    int  n_checks;
    int  n_err;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy count, acceptance and sticky overflow from the rules of the queue.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_lvl <= 0;
            exp_rdy <= 1'b0;
            exp_ovf <= 1'b0;
            sb.delete();
        end else begin
            int nxt;
            nxt = exp_lvl;
            if (bus.valid_in_i && !exp_rdy) exp_ovf <= 1'b1;
            if (bus.flush_i) begin
                nxt = 0;
                sb.delete();
            end else begin
                if (bus.valid_in_i && exp_rdy)     nxt = nxt + 1;
                if (exp_lvl > 0 && bus.ready_in_i) nxt = nxt - 1;
            end
            exp_lvl <= nxt;
            exp_rdy <= (nxt < DEPTH);
        end
    end

    // Monitor: status vs model, head vs scoreboard, and pop-compare on every consumed word.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_level", DATA_W'(bus.level_o), '0);
            chk("rst_valid", DATA_W'(bus.valid_out_o), '0);
            chk("rst_ready", DATA_W'(bus.ready_out_o), '0);
            chk("rst_ovf",   DATA_W'(bus.overflow_o), '0);
            chk("rst_data",  bus.data_out_o, '0);
        end else begin
            chk("level", DATA_W'(bus.level_o), DATA_W'(exp_lvl));
            chk("ready", DATA_W'(bus.ready_out_o), DATA_W'(exp_rdy));
            chk("valid", DATA_W'(bus.valid_out_o), DATA_W'(exp_lvl != 0));
            chk("ovf",   DATA_W'(bus.overflow_o), DATA_W'(exp_ovf));
            if (exp_lvl == 0) begin
                chk("empty_data", bus.data_out_o, '0);
            end else if (sb.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL head: got %0h want <none, scoreboard empty>", bus.data_out_o);
            end else begin
                chk("head", bus.data_out_o, sb[0]);
            end
            if (bus.valid_out_o && bus.ready_in_i && !bus.flush_i) begin
                if (sb.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL pop: got %0h want <none, scoreboard empty>", bus.data_out_o);
                end else begin
                    chk("pop", bus.data_out_o, sb.pop_front());
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit f);
        @(posedge clk);
        #0.3;
        bus.valid_in_i = v;
        bus.data_in_i  = d;
        bus.ready_in_i = r;
        bus.flush_i    = f;
        if (rst_n && v && exp_rdy && !f) sb.push_back(d);
    endtask

    initial begin
        logic [DATA_W-1:0] xw;
        logic [DATA_W-1:0] zw;
        logic [DATA_W-1:0] rw;
        xw = 'x;
        zw = 'z;

        bus.valid_in_i = 1'b1;
        bus.data_in_i  = '0;
        bus.ready_in_i = 1'b0;
        bus.flush_i    = 1'b0;
        rst_n          = 1'b0;
        #6.6;
        rst_n = 1'b1;

        // Fill to full, then one refused push
        for (int i = 1; i <= 4; i++) drive(1'b1, DATA_W'(i), 1'b0, 1'b0);
        drive(1'b1, DATA_W'(5), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        // Drain
        repeat (6) drive(1'b0, '0, 1'b1, 1'b0);
        // Streaming with counter payload
        for (int i = 0; i < 10; i++) drive(1'b1, DATA_W'(100 + i), 1'b1, 1'b0);
        repeat (2) drive(1'b0, '0, 1'b1, 1'b0);
        // Flush at level 3 with a concurrent push
        repeat (3) drive(1'b1, DATA_W'('hA), 1'b0, 1'b0);
        drive(1'b1, DATA_W'('hB), 1'b1, 1'b1);
        repeat (2) drive(1'b0, '0, 1'b1, 1'b0);
        // X/Z payloads stored verbatim
        drive(1'b1, xw, 1'b0, 1'b0);
        drive(1'b1, zw, 1'b0, 1'b0);
        drive(1'b1, DATA_W'('h12345678), 1'b0, 1'b0);
        repeat (5) drive(1'b0, '0, 1'b1, 1'b0);
        // Random traffic
        repeat (300) begin
            rw = {$urandom(), $urandom(), $urandom(), $urandom()};
            drive(bit'($urandom_range(0, 9) < 7), rw, bit'($urandom_range(0, 9) < 6),
                  bit'($urandom_range(0, 99) < 3));
        end
        // Reset in the middle of traffic
        drive(1'b1, DATA_W'('hC), 1'b0, 1'b0);
        drive(1'b1, DATA_W'('hD), 1'b0, 1'b0);
        #0.2;
        rst_n = 1'b0;
        bus.valid_in_i = 1'b0;
        repeat (2) @(posedge clk);
        #0.6;
        rst_n = 1'b1;
        drive(1'b1, DATA_W'('hE), 1'b1, 1'b0);
        repeat (4) drive(1'b0, '0, 1'b1, 1'b0);

        @(posedge clk);
        #0.5;
        chk("sb_drained", DATA_W'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
